// File: rtl/serial_addsub16_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
package serial_addsub16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/FA.sv
// One-bit full-adder cell used as the serial bit-slice.
module FA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub16.sv
// Bit-serial two's-complement adder/subtractor: one result bit per clock,
// LSB first, through a single full-adder slice.
module serial_addsub16
  import serial_addsub16_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] psum;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sum_final;

  FA u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit  = (state == RUN) && (cnt == LAST);
  assign sum_final = {fa_s, psum};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      psum   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= op_sub ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
            psum  <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= {fa_s, psum[WIDTH-2:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // carry currently holds the carry into the MSB slice
            result <= sum_final;
            cout   <= fa_cout;
            ovf    <= carry ^ fa_cout;
            zero   <= (sum_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
